// File: rtl/l15_resp_pkg.sv
// l15_resp_pkg: shared types for the memory-side L1.5 responder.
//   - l15_req_t / l15_rtrn_t : core <-> responder buses (OpenPiton-style field names)
//   - entry_t                : one pending request in the return FIFO
//   - request / return type encodings
//   - size_mask()            : l15_size + byte offset -> byte-lane mask within a 64-bit word
package l15_resp_pkg;

    // Request types (OpenPiton encoding)
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [4:0] CAS1_RQ  = 5'b00110;
    localparam logic [4:0] IMISS_RQ = 5'b10000;

    // Return types
    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;

    typedef struct packed {
        logic        val;
        logic [4:0]  rqtype;
        logic [2:0]  size;
        logic [39:0] address;
        logic [63:0] data;
        logic        threadid;
        logic        req_ack;
    } l15_req_t;

    typedef struct packed {
        logic        ack;
        logic        header_ack;
        logic        val;
        logic [3:0]  returntype;
        logic [63:0] data_0;
        logic [63:0] data_1;
        logic [63:0] data_2;
        logic [63:0] data_3;
        logic        threadid;
    } l15_rtrn_t;

    // idx holds the full 16-byte line address; the top keeps only the bits
    // that fit its memory, so the FIFO is independent of MemLines.
    typedef struct packed {
        logic [4:0]  rqtype;
        logic        threadid;
        logic [35:0] idx;
    } entry_t;

    // Byte-lane mask of a naturally aligned 1/2/4/8-byte access at offset off.
    function automatic logic [7:0] size_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size[1:0])
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/l15_mem_responder_fifo.sv
// l15_resp_fifo: synchronous FIFO of entry_t used to keep pending requests in order.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset (flushes pointers)
//   push_i, push_data_i  enqueue (caller guarantees !full_o)
//   pop_i             dequeue head (caller guarantees !empty_o)
//   full_o, empty_o   status
//   head_o            oldest entry
//   count_o           occupancy
module l15_resp_fifo
    import l15_resp_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output entry_t                   head_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int PW = $clog2(Depth);

    entry_t        mem_q [Depth];
    logic [PW:0]   wptr_q, rptr_q;

    // Extra pointer MSB distinguishes full from empty.
    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign head_o  = mem_q[rptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[PW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/l15_mem_responder.sv
// l15_mem_responder: memory-side responder of the core's l15_req/l15_rtrn interface.
// Accepts ifill/load/store requests, serves them in order from a line-organised
// memory after Latency cycles and returns OpenPiton-style responses.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   l15_req_i       request bus from the core (includes req_ack for returns)
//   l15_rtrn_o      return bus (ack/header_ack for requests, val/type/data for returns)
//   pre_we_i, pre_idx_i, pre_data_i  backdoor line preload
//   err_o           sticky flag: an unsupported rqtype was accepted
// Optional feature: define L15_RESP_STALL_EN to enable an LFSR-driven accept stall.
module l15_mem_responder
    import l15_resp_pkg::*;
#(
    parameter int          Depth     = 4,
    parameter int          Latency   = 8,
    parameter int          MemLines  = 1024,
    parameter logic [15:0] StallSeed = 16'hACE1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  l15_req_t                    l15_req_i,
    output l15_rtrn_t                   l15_rtrn_o,
    input  logic                        pre_we_i,
    input  logic [$clog2(MemLines)-1:0] pre_idx_i,
    input  logic [127:0]                pre_data_i,
    output logic                        err_o
);
    localparam int IdxW = $clog2(MemLines);
    localparam int CntW = (Latency < 2) ? 1 : $clog2(Latency + 1);
    localparam int FW   = $clog2(Depth) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_e;

    logic [127:0] mem_q [MemLines];

    state_e        state_q;
    logic [CntW-1:0] cnt_q;
    logic          ack_q, blank_q, err_q;
    logic          rval_q, rthr_q;
    logic [3:0]    rtype_q;
    logic [63:0]   rd0_q, rd1_q, rd2_q, rd3_q;

    logic          full, empty, stall, accept, supported, push, pop;
    entry_t        head, push_e;
    logic [FW-1:0] fifo_cnt;

    // ---------------- optional accept stall ----------------
`ifdef L15_RESP_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= StallSeed;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    logic [15:0] unused_seed;
    assign unused_seed = StallSeed;
    assign stall = 1'b0;
`endif

    // ---------------- accept ----------------
    // blank_q masks the cycle right after an accept: the core still holds
    // val there because it only sees the ack in that same cycle.
    assign accept    = l15_req_i.val & ~full & ~blank_q & ~stall;
    assign supported = (l15_req_i.rqtype == LOAD_RQ) || (l15_req_i.rqtype == STORE_RQ) ||
                       (l15_req_i.rqtype == IMISS_RQ);
    assign push      = accept & supported;
    assign pop       = (state_q == VALID) & l15_req_i.req_ack;
    assign push_e    = '{rqtype: l15_req_i.rqtype, threadid: l15_req_i.threadid,
                         idx: l15_req_i.address[39:4]};

    l15_resp_fifo #(.Depth(Depth)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (push_e),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    // ---------------- memory ----------------
    logic [IdxW-1:0] st_idx;
    logic [7:0]      st_mask;
    logic            st_we;
    assign st_idx  = l15_req_i.address[IdxW+3:4];
    assign st_mask = size_mask(l15_req_i.size, l15_req_i.address[2:0]);
    assign st_we   = accept & (l15_req_i.rqtype == STORE_RQ);

    // Store bytes are assigned after the backdoor write so they win on a collision.
    always_ff @(posedge clk_i) begin
        if (pre_we_i) mem_q[pre_idx_i] <= pre_data_i;
        if (st_we) begin
            for (int b = 0; b < 16; b++) begin
                if ((l15_req_i.address[3] == b[3]) && st_mask[b[2:0]])
                    mem_q[st_idx][8*b +: 8] <= l15_req_i.data[8*b[2:0] +: 8];
            end
        end
    end

    // ---------------- return data for current head ----------------
    logic [IdxW-1:0] hd_idx;
    logic [127:0]    ln, ln_lo, ln_hi;
    logic [3:0]      ret_type;
    logic [63:0]     ret_d0, ret_d1, ret_d2, ret_d3;
    logic            unused_hd;

    assign hd_idx    = head.idx[IdxW-1:0];
    assign ln        = mem_q[hd_idx];
    assign ln_lo     = mem_q[{hd_idx[IdxW-1:1], 1'b0}];
    assign ln_hi     = mem_q[{hd_idx[IdxW-1:1], 1'b1}];
    assign unused_hd = ^head.idx;

    always_comb begin
        ret_type = ST_ACK;
        ret_d0   = '0;
        ret_d1   = '0;
        ret_d2   = '0;
        ret_d3   = '0;
        case (head.rqtype)
            LOAD_RQ: begin
                ret_type = LOAD_RET;
                ret_d0   = ln[63:0];
                ret_d1   = ln[127:64];
            end
            IMISS_RQ: begin
                ret_type = IFILL_RET;
                ret_d0   = ln_lo[63:0];
                ret_d1   = ln_lo[127:64];
                ret_d2   = ln_hi[63:0];
                ret_d3   = ln_hi[127:64];
            end
            default: ;
        endcase
    end

    // ---------------- ack / error / return FSM ----------------
    // A head that arrives while IDLE is seen one cycle late, so the counter
    // starts at Latency-1 there; after a pop with more entries queued the
    // next head is already visible and the counter starts at Latency. Both
    // give a return Latency+1 cycles after the head becomes visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
            rval_q  <= 1'b0;
            rthr_q  <= 1'b0;
            rtype_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rd3_q   <= '0;
        end else begin
            ack_q   <= accept;
            blank_q <= accept;
            if (accept && !supported) err_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        if (Latency == 0) begin
                            state_q <= VALID;
                            rval_q  <= 1'b1;
                            rtype_q <= ret_type;
                            rthr_q  <= head.threadid;
                            rd0_q   <= ret_d0;
                            rd1_q   <= ret_d1;
                            rd2_q   <= ret_d2;
                            rd3_q   <= ret_d3;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CntW'(Latency - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= VALID;
                        rval_q  <= 1'b1;
                        rtype_q <= ret_type;
                        rthr_q  <= head.threadid;
                        rd0_q   <= ret_d0;
                        rd1_q   <= ret_d1;
                        rd2_q   <= ret_d2;
                        rd3_q   <= ret_d3;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                VALID: begin
                    if (l15_req_i.req_ack) begin
                        rval_q <= 1'b0;
                        if (fifo_cnt > FW'(1)) begin
                            state_q <= WAIT;
                            cnt_q   <= CntW'(Latency);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_o      = err_q;
    assign l15_rtrn_o = '{ack: ack_q, header_ack: ack_q, val: rval_q, returntype: rtype_q,
                          data_0: rd0_q, data_1: rd1_q, data_2: rd2_q, data_3: rd3_q,
                          threadid: rthr_q};

endmodule

// File: tb/tb_l15_mem_responder.sv
// Self-checking bench for l15_mem_responder: directed scenarios plus a
// randomized load/store/ifill mix checked against a byte-level memory model.
module tb_l15_mem_responder;
    import l15_resp_pkg::*;

    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    l15_req_t     req;
    l15_rtrn_t    rtrn;
    logic         pre_we;
    logic [9:0]   pre_idx;
    logic [127:0] pre_data;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc;

    logic [127:0] mdl [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l15_mem_responder #(.Depth(4), .Latency(LAT), .MemLines(1024)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .l15_req_i  (req),
        .l15_rtrn_o (rtrn),
        .pre_we_i   (pre_we),
        .pre_idx_i  (pre_idx),
        .pre_data_i (pre_data),
        .err_o      (err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [127:0] d);
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        tick();
        pre_we = 1'b0;
        mdl[idx] = d;
    endtask

    // Byte k of the store lands at line byte (off+k), taken from data lane (off%8+k).
    task automatic model_store(input logic [39:0] a, input logic [2:0] sz, input logic [63:0] d);
        int off;
        int line;
        off  = int'(a[3:0]);
        line = int'(a[13:4]);
        for (int k = 0; k < (1 << sz); k++)
            mdl[line][8*(off+k) +: 8] = d[8*((off % 8) + k) +: 8];
    endtask

    task automatic send(input logic [4:0] rq, input logic [39:0] a, input logic [2:0] sz,
                        input logic [63:0] d, input logic th);
        bit got;
        got = 1'b0;
        req.val = 1'b1; req.rqtype = rq; req.address = a; req.size = sz;
        req.data = d; req.threadid = th;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rtrn.ack) begin got = 1'b1; break; end
        end
        ack_cyc = cyc;
        req.val = 1'b0;
        chk("req_acked", got, 1'b1);
        chk("header_ack", rtrn.header_ack, got);
    endtask

    task automatic wait_ret(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rtrn.val) begin ok = 1'b1; break; end
            tick();
        end
        chk({tag, "_ret_seen"}, ok, 1'b1);
    endtask

    task automatic ret_ack();
        req.req_ack = 1'b1;
        tick();
        req.req_ack = 1'b0;
        chk("val_drop", rtrn.val, 1'b0);
    endtask

    task automatic chk_ret(input string tag, input logic [3:0] t, input logic th,
                           input logic [255:0] d);
        chk({tag, "_type"}, rtrn.returntype, t);
        chk({tag, "_thr"}, rtrn.threadid, th);
        chk({tag, "_data"}, {rtrn.data_3, rtrn.data_2, rtrn.data_1, rtrn.data_0}, d);
    endtask

    task automatic no_ret(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rtrn.val) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    logic [127:0] l5, l102, l103, ln;
    logic [127:0] lv [6];
    logic [255:0] snap;
    int nack, nret, a0, sz, off, line, r;
    logic [63:0] d;
    logic th;

    initial begin
        rst_n = 1'b0; req = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        tick(); tick();
        chk("rst_rtrn", rtrn, '0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: preload + load, latency
        l5 = 128'h00112233445566778899AABBCCDDEEFF;
        preload(10'd5, l5);
        send(LOAD_RQ, 40'h50, 3'd3, 64'h0, 1'b1);
        a0 = ack_cyc;
        tick();
        chk("ack_one_cycle", rtrn.ack, 1'b0);
        wait_ret("t1");
        chk("t1_latency", cyc - a0, LAT + 1);
        chk_ret("t1", LOAD_RET, 1'b1, {128'h0, 64'h0011223344556677, 64'h8899AABBCCDDEEFF});
        ret_ack();

        // 2: byte store then load
        send(STORE_RQ, 40'h53, 3'd0, 64'h00000000_5A000000, 1'b0);
        wait_ret("t2s");
        chk_ret("t2s", ST_ACK, 1'b0, '0);
        ret_ack();
        send(LOAD_RQ, 40'h50, 3'd3, 64'h0, 1'b0);
        wait_ret("t2l");
        chk_ret("t2l", LOAD_RET, 1'b0, {128'h0, 64'h0011223344556677, 64'h8899AABB5ADDEEFF});
        ret_ack();
        l5 = 128'h0011223344556677_8899AABB5ADDEEFF;

        // 3: ifill pair
        l102 = {$urandom, $urandom, $urandom, $urandom};
        l103 = {$urandom, $urandom, $urandom, $urandom};
        preload(10'h102, l102);
        preload(10'h103, l103);
        send(IMISS_RQ, 40'h1020, 3'd3, 64'h0, 1'b1);
        wait_ret("t3");
        chk_ret("t3", IFILL_RET, 1'b1, {l103, l102});
        ret_ack();

        // 4: six back-to-back loads, FIFO depth 4, returns held off
        for (int k = 0; k < 6; k++) begin
            lv[k] = {$urandom, $urandom, $urandom, $urandom};
            preload(10'(10'h300 + k), lv[k]);
        end
        nack = 0; nret = 0;
        req.val = 1'b1; req.rqtype = LOAD_RQ; req.size = 3'd3; req.threadid = 1'b0;
        req.address = 40'h3000;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rtrn.ack) begin
                nack++;
                if (nack < 6) req.address = 40'h3000 + 40'(nack * 16);
                else req.val = 1'b0;
            end
        end
        chk("t4_acks_when_full", nack, 4);
        for (int i = 0; i < 800 && nret < 6; i++) begin
            tick();
            req.req_ack = 1'b0;
            if (rtrn.ack) begin
                nack++;
                if (nack < 6) req.address = 40'h3000 + 40'(nack * 16);
                else req.val = 1'b0;
            end
            if (rtrn.val) begin
                chk_ret("t4", LOAD_RET, 1'b0, {128'h0, lv[nret]});
                nret++;
                req.req_ack = 1'b1;
            end
        end
        tick();
        req.req_ack = 1'b0; req.val = 1'b0;
        chk("t4_total_acks", nack, 6);
        chk("t4_total_rets", nret, 6);

        // 5: return held 10 cycles
        send(LOAD_RQ, 40'h3020, 3'd3, 64'h0, 1'b1);
        wait_ret("t5");
        snap = {rtrn.data_3, rtrn.data_2, rtrn.data_1, rtrn.data_0};
        chk("t5_data", snap, {128'h0, lv[2]});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_val_hold", rtrn.val, 1'b1);
            chk("t5_data_hold", {rtrn.data_3, rtrn.data_2, rtrn.data_1, rtrn.data_0}, snap);
        end
        ret_ack();
        no_ret("t5_single_pop", 30);

        // 6: reset with 3 pending
        for (int k = 0; k < 3; k++) send(LOAD_RQ, 40'h3000 + 40'(k * 16), 3'd3, 64'h0, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        chk("t6_pre_val", rtrn.val, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_rtrn", rtrn, '0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        send(LOAD_RQ, 40'h50, 3'd3, 64'h0, 1'b1);
        wait_ret("t6");
        chk_ret("t6", LOAD_RET, 1'b1, {128'h0, l5});
        ret_ack();
        no_ret("t6_no_stale", 30);
        chk("t6_err_clear", err, 1'b0);
        send(CAS1_RQ, 40'h50, 3'd3, 64'h1, 1'b0);
        chk("t6_err_set", err, 1'b1);
        no_ret("t6_atomic_no_ret", 30);

        // randomized mix against the model
        for (int k = 0; k < 8; k++)
            preload(10'(10'h200 + k), {$urandom, $urandom, $urandom, $urandom});
        for (int it = 0; it < 40; it++) begin
            r    = $urandom_range(0, 9);
            line = 'h200 + $urandom_range(0, 7);
            th   = 1'($urandom_range(0, 1));
            if (r < 4) begin
                sz  = $urandom_range(0, 3);
                off = $urandom_range(0, 15) & ~((1 << sz) - 1);
                d   = {$urandom, $urandom};
                send(STORE_RQ, 40'(line * 16 + off), 3'(sz), d, th);
                model_store(40'(line * 16 + off), 3'(sz), d);
                wait_ret("rnd_st");
                chk_ret("rnd_st", ST_ACK, th, '0);
            end else if (r < 8) begin
                send(LOAD_RQ, 40'(line * 16), 3'd3, 64'h0, th);
                wait_ret("rnd_ld");
                ln = mdl[line];
                chk_ret("rnd_ld", LOAD_RET, th, {128'h0, ln});
            end else begin
                send(IMISS_RQ, 40'(line * 16 + $urandom_range(0, 15)), 3'd3, 64'h0, th);
                wait_ret("rnd_if");
                chk_ret("rnd_if", IFILL_RET, th, {mdl[line | 1], mdl[line & ~1]});
            end
            ret_ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
